block_emitter: RTL and testbench
================================

BLOCK_EMITTER -- requirements
Module: block_emitter

Interface
REQ-001 Parameter: DEPTH_W, default 8, width of nesting-depth counter; maximum depth is 2^DEPTH_W-1.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts command this cycle.
REQ-006 cmd_op  input  1  0 = BEGIN, 1 = END.
REQ-007 cmd_upper  input  1  1 = emit letters uppercase, 0 = lowercase; sampled with the command.
REQ-008 flush  input  1  request to close all open blocks (see Configuration).
REQ-009 out_char  output  8  ASCII character.
REQ-010 out_valid  output  1  out_char valid.
REQ-011 out_ready  input  1  downstream accepts out_char.
REQ-012 depth  output  DEPTH_W  current count of unclosed BEGINs.
REQ-013 err  output  1  sticky protocol error.
REQ-014 balanced  output  1  depth==0 and err==0.

Function
REQ-015 Block SHALL serialize commands into the space-separated word stream that the team's block checker consumes: BEGIN -> "begin " (6 chars), END -> "end " (4 chars), trailing char 0x20.
REQ-016 Uppercase SHALL apply to letters only ("BEGIN ", "END "); space is always 0x20.
REQ-017 FSM states SHALL be IDLE, EMIT, FLUSH; a char-index counter (0..5) SHALL select the current character.
REQ-018 cmd_ready SHALL be 1 only in IDLE with flush not being serviced; command accepted when cmd_valid && cmd_ready.
REQ-019 Valid command accepted in cycle N SHALL present its first char with out_valid=1 in cycle N+1 (state EMIT).
REQ-020 out_char SHALL hold stable while out_valid && !out_ready; index advances only on out_valid && out_ready.
REQ-021 Handshake on the last char (the space) SHALL return the FSM to IDLE next cycle, out_valid=0 in that cycle; no back-to-back overlap.
REQ-022 Accepted BEGIN SHALL increment depth at acceptance; accepted END SHALL decrement depth at acceptance.
REQ-023 END accepted with depth==0 SHALL be rejected: no chars emitted, depth unchanged, err set, FSM stays IDLE.
REQ-024 BEGIN accepted with depth==max SHALL be rejected likewise; depth never wraps.
REQ-025 err SHALL remain 1 until reset; emission of later legal commands continues normally.
REQ-026 out_valid SHALL be 0 in IDLE.

Reset
REQ-027 On reset low, regardless of clock or in-progress word: state=IDLE, index=0, depth=0, err=0, out_valid=0, out_char=0x00, cmd_ready=1 after release, balanced=1.
REQ-028 A partially emitted word SHALL be abandoned on reset; no remainder emitted afterward.

Configuration
REQ-029 Macro BLOCK_EMITTER_AUTOCLOSE_EN: when defined, flush sampled high in IDLE (priority over cmd_valid, cmd_ready=0 that cycle) SHALL enter FLUSH and emit "end " (case per cmd_upper at that cycle) repeatedly, decrementing depth per completed word, until depth==0, then IDLE; flush with depth==0 SHALL be a no-op.
REQ-030 When BLOCK_EMITTER_AUTOCLOSE_EN is undefined, flush SHALL be ignored and FLUSH state SHALL not exist.

Verification
REQ-031 Reset, BEGIN lower, out_ready=1 -> chars 0x62,0x65,0x67,0x69,0x6E,0x20 in cycles N+1..N+6, depth=1, balanced=0.
REQ-032 BEGIN upper then END upper -> "BEGIN END " stream, depth 1 then 0, balanced=1.
REQ-033 END at depth 0 -> no out_valid, err=1, depth=0, balanced=0; subsequent BEGIN still emits "begin ".
REQ-034 BEGIN with out_ready low 3 cycles on char 'g' -> out_char=0x67 held 4 cycles, stream otherwise intact.
REQ-035 Reset asserted after "be" emitted -> out_valid=0 immediately, depth=0; post-reset END sets err.
REQ-036 With BLOCK_EMITTER_AUTOCLOSE_EN: three BEGINs, flush pulse -> "end end end ", depth 3->0, balanced=1; without macro, same stimulus -> no output, depth=3.

Source files
------------

// File: rtl/block_emitter.sv
// block_emitter: serializes BEGIN/END commands into "begin "/"end " ASCII words and tracks nesting depth.
// Optional BLOCK_EMITTER_AUTOCLOSE_EN adds a FLUSH state that closes every open block on request.
module block_emitter #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic               cmd_upper,
    input  logic               flush,
    output logic [7:0]         out_char,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output logic               balanced
);
`ifdef BLOCK_EMITTER_AUTOCLOSE_EN
    typedef enum logic [1:0] {IDLE, EMIT, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif
    localparam logic [DEPTH_W-1:0] MAX = {DEPTH_W{1'b1}};
    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               op_q, op_d;
    logic               upper_q, upper_d;
    logic               flush_go;
    logic [2:0]         last;
    logic [7:0]         lc;
`ifdef BLOCK_EMITTER_AUTOCLOSE_EN
    assign flush_go = state_q == IDLE && flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_go = 1'b0;
`endif
    assign cmd_ready = state_q == IDLE && !flush_go;
    assign out_valid = state_q != IDLE;
    assign depth     = depth_q;
    assign err       = err_q;
    assign balanced  = depth_q == '0 && !err_q;
    assign last      = op_q ? 3'd3 : 3'd5;
    always_comb begin
        lc = op_q ? (idx_q == 3'd0 ? 8'h65 : idx_q == 3'd1 ? 8'h6E : idx_q == 3'd2 ? 8'h64 : 8'h20)
                  : (idx_q == 3'd0 ? 8'h62 : idx_q == 3'd1 ? 8'h65 : idx_q == 3'd2 ? 8'h67 :
                     idx_q == 3'd3 ? 8'h69 : idx_q == 3'd4 ? 8'h6E : 8'h20);
        out_char = !out_valid ? 8'h00 : (upper_q && lc != 8'h20) ? lc - 8'h20 : lc;
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        depth_d = depth_q;
        err_d   = err_q;
        op_d    = op_q;
        upper_d = upper_q;
        if (cmd_valid && cmd_ready) begin
            op_d    = cmd_op;
            upper_d = cmd_upper;
            idx_d   = 3'd0;
            // Underflow/overflow commands are dropped silently apart from the sticky error.
            if (cmd_op ? depth_q == '0 : depth_q == MAX) begin
                err_d = 1'b1;
            end else begin
                state_d = EMIT;
                depth_d = cmd_op ? depth_q - DEPTH_W'(1) : depth_q + DEPTH_W'(1);
            end
        end
`ifdef BLOCK_EMITTER_AUTOCLOSE_EN
        if (flush_go && depth_q != '0) begin
            state_d = FLUSH;
            op_d    = 1'b1;
            upper_d = cmd_upper;
            idx_d   = 3'd0;
        end
`endif
        if (out_valid && out_ready) begin
            idx_d = idx_q == last ? 3'd0 : idx_q + 3'd1;
            if (idx_q == last) begin
                state_d = IDLE;
`ifdef BLOCK_EMITTER_AUTOCLOSE_EN
                if (state_q == FLUSH) begin
                    depth_d = depth_q - DEPTH_W'(1);
                    state_d = depth_q == DEPTH_W'(1) ? IDLE : FLUSH;
                end
`endif
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            depth_q <= '0;
            err_q   <= 1'b0;
            op_q    <= 1'b0;
            upper_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            op_q    <= op_d;
            upper_q <= upper_d;
        end
    end
endmodule

// File: tb/tb_block_emitter.sv
// tb_block_emitter: directed bench for block_emitter with hand-computed character streams.
module tb_block_emitter;
    localparam int DW = 2;
    logic          clk = 1'b0;
    logic          rst_n, cmd_valid, cmd_ready, cmd_op, cmd_upper, flush;
    logic [7:0]    out_char;
    logic          out_valid, out_ready;
    logic [DW-1:0] depth;
    logic          err, balanced;
    int            n_checks = 0;
    int            n_errors = 0;

    block_emitter #(.DEPTH_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_upper(cmd_upper), .flush(flush), .out_char(out_char),
        .out_valid(out_valid), .out_ready(out_ready), .depth(depth), .err(err),
        .balanced(balanced)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input logic op, input logic upper);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_upper = upper;
        for (n = 0; n < 20 && !cmd_ready; n++) @(negedge clk);
        check("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic expect_word(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            check("out_valid", out_valid, 1);
            check($sformatf("char%0d", i), out_char, s[i]);
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_char"}, out_char, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_depth", depth, 0);
        check("rst_err", err, 0);
        check("rst_balanced", balanced, 1);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", cmd_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_upper = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #3;
        check("init_char", out_char, 8'h00);
        do_reset();

        // lowercase BEGIN
        send(1'b0, 1'b0);
        check("begin_depth", depth, 1);
        check("begin_balanced", balanced, 0);
        expect_word("begin ");
        expect_idle("after_begin");

        // uppercase BEGIN then END
        do_reset();
        send(1'b0, 1'b1);
        check("up_depth1", depth, 1);
        expect_word("BEGIN ");
        send(1'b1, 1'b1);
        check("up_depth0", depth, 0);
        expect_word("END ");
        expect_idle("after_end");
        check("up_balanced", balanced, 1);

        // END at depth 0
        do_reset();
        send(1'b1, 1'b0);
        expect_idle("underflow");
        check("underflow_err", err, 1);
        check("underflow_depth", depth, 0);
        check("underflow_balanced", balanced, 0);
        send(1'b0, 1'b0);
        expect_word("begin ");
        check("err_sticky", err, 1);

        // stall on 'g'
        do_reset();
        send(1'b0, 1'b0);
        expect_word("be");
        @(negedge clk);
        check("stall_g0", out_char, 8'h67);
        out_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall_g%0d", i), out_char, 8'h67);
            check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        expect_word("in ");
        expect_idle("after_stall");

        // reset mid-word
        do_reset();
        send(1'b0, 1'b0);
        expect_word("be");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_depth", depth, 0);
        check("midrst_char", out_char, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("midrst_idle1");
        expect_idle("midrst_idle2");
        send(1'b1, 1'b0);
        expect_idle("midrst_end");
        check("midrst_err", err, 1);

        // flush after three BEGINs
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0);
            expect_word("begin ");
        end
        @(negedge clk);
        check("pre_flush_depth", depth, 3);
        flush = 1'b1;
`ifdef BLOCK_EMITTER_AUTOCLOSE_EN
        #1 check("flush_ready", cmd_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_depth_start", depth, 3);
        expect_word("end end end ");
        expect_idle("after_flush");
        check("flush_depth", depth, 0);
        check("flush_balanced", balanced, 1);
`else
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < 4; i++) expect_idle("noflush");
        check("noflush_depth", depth, 3);
        check("noflush_balanced", balanced, 0);
`endif

        // overflow at max depth (3 with DW=2)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b1);
            expect_word("BEGIN ");
        end
        send(1'b0, 1'b1);
        expect_idle("overflow");
        check("overflow_depth", depth, 3);
        check("overflow_err", err, 1);
        send(1'b1, 1'b0);
        expect_word("end ");
        check("overflow_after_depth", depth, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
